// File: rtl/seq_detect_param.sv
// Serial pattern detector with selectable overlap, one-cycle input stage and registered det pulse.
// Optional saturating match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detect_param #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             in,
  input  logic             clr,
  input  logic             overlap,
  input  logic [PAT_W-1:0] pattern,
  output logic             det,
  output logic [CNT_W-1:0] match_cnt
);

  // state | meaning
  // fill  | number of accepted bits toward the next match, 0..PAT_W (saturates)
  localparam int FW = $clog2(PAT_W + 1);

  logic             in_q;
  logic             en_q;
  logic [PAT_W-1:0] history;
  logic [FW-1:0]    fill;

  logic [PAT_W-1:0] history_nx;
  logic [FW-1:0]    fill_nx;
  logic             match;

  always_comb begin
    history_nx = {history[PAT_W-2:0], in_q};
    fill_nx    = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
    match      = en_q && (fill_nx == FW'(PAT_W)) && (history_nx == pattern);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_q    <= 1'b0;
      en_q    <= 1'b0;
      history <= '0;
      fill    <= '0;
      det     <= 1'b0;
    end else begin
      in_q <= in;
      if (clr) begin
        en_q    <= 1'b0;
        history <= '0;
        fill    <= '0;
        det     <= 1'b0;
      end else begin
        en_q <= en;
        det  <= match;
        if (en_q) begin
          history <= history_nx;
          // Non-overlapping mode restarts progress so the next match needs PAT_W fresh bits.
          fill    <= (match && !overlap) ? '0 : fill_nx;
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      match_cnt <= '0;
    end else if (clr) begin
      match_cnt <= '0;
    end else if (match && (match_cnt != {CNT_W{1'b1}})) begin
      match_cnt <= match_cnt + CNT_W'(1);
    end
  end
`else
  assign match_cnt = '0;
`endif

endmodule
